pc_plus4: RTL and testbench

PC_PLUS4 -- requirements
Module: pc_plus4

---
 rtl/pc_plus4_pkg.sv | 20 ++
 rtl/pc_adder.sv | 14 +
 rtl/pc_plus4.sv | 47 ++++
 tb/tb_pc_plus4.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/pc_plus4_pkg.sv
// Shared fetch-stage constants and helpers for the processor front end.
package pc_plus4_pkg;

  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned PC_STEP  = 4;
  localparam logic [PC_WIDTH-1:0] PC_RESET_VECTOR = 32'h0000_0000;

  // Instructions are word aligned; the low bits of a valid PC are zero.
  localparam int unsigned PC_ALIGN_BITS = 2;

  typedef struct packed {
    logic [PC_WIDTH-1:0] nextPC;
    logic                wrap;
  } pcStep_t;

  function automatic logic isMisaligned(input logic [PC_ALIGN_BITS-1:0] lowBits);
    return lowBits != '0;
  endfunction

endpackage

// File: rtl/pc_adder.sv
// Unsigned WIDTH-bit adder with carry-out.
module pc_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);

  // Zero-extend both operands by one bit so the carry lands in the MSB.
  assign {carryOut, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/pc_plus4.sv
// Next-PC generator: combinational fromPC + STEP with wrap/misaligned flags and a registered copy.
module pc_plus4
  import pc_plus4_pkg::*;
#(
  parameter int unsigned     WIDTH        = PC_WIDTH,
  parameter int unsigned     STEP         = PC_STEP,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] fromPC,
  output logic [WIDTH-1:0] NextoPC,
  output logic             wrap,
  output logic             misaligned,
  output logic [WIDTH-1:0] NextoPC_q,
  output logic             wrap_q
);

  localparam logic [WIDTH-1:0] STEP_VAL = WIDTH'(STEP);

  pc_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a       (fromPC),
    .b       (STEP_VAL),
    .sum     (NextoPC),
    .carryOut(wrap)
  );

  // Informational only: the sum is still produced for misaligned inputs.
  assign misaligned = isMisaligned(fromPC[PC_ALIGN_BITS-1:0]);

  // Reset wins over en; both are sampled only on the rising edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (reset) begin
      NextoPC_q <= RESET_VECTOR;
      wrap_q    <= 1'b0;
    end else if (en) begin
      NextoPC_q <= NextoPC;
      wrap_q    <= wrap;
    end
  end

endmodule

// File: tb/tb_pc_plus4.sv
// Self-checking bench for pc_plus4: combinational vector table plus register sequences.
module tb_pc_plus4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] fromPC;
  logic [31:0] NextoPC;
  logic        wrap;
  logic        misaligned;
  logic [31:0] NextoPC_q;
  logic        wrap_q;

  int errors = 0;
  int checks = 0;

  pc_plus4 dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .fromPC    (fromPC),
    .NextoPC   (NextoPC),
    .wrap      (wrap),
    .misaligned(misaligned),
    .NextoPC_q (NextoPC_q),
    .wrap_q    (wrap_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] expNext;
    logic        expWrap;
    logic        expMis;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0};
    vecs[1]  = '{32'h0000_0004, 32'h0000_0008, 1'b0, 1'b0};
    vecs[2]  = '{32'h0000_0010, 32'h0000_0014, 1'b0, 1'b0};
    vecs[3]  = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4]  = '{32'h7FFF_FFFC, 32'h8000_0000, 1'b0, 1'b0};
    vecs[5]  = '{32'h8000_0000, 32'h8000_0004, 1'b0, 1'b0};
    vecs[6]  = '{32'h0000_0002, 32'h0000_0006, 1'b0, 1'b1};
    vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 1'b1};
    vecs[8]  = '{32'hFFFF_FFFE, 32'h0000_0002, 1'b1, 1'b1};
    vecs[9]  = '{32'h0000_0003, 32'h0000_0007, 1'b0, 1'b1};
    vecs[10] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b0, 1'b0};
    vecs[11] = '{32'h1234_5679, 32'h1234_567D, 1'b0, 1'b1};

    reset  = 1'b1;
    en     = 1'b0;
    fromPC = 32'h0000_0000;

    // Reset state, with en low.
    tick();
    check("reset_q", NextoPC_q, 32'h0000_0000);
    check("reset_wrap_q", {31'b0, wrap_q}, 32'h0);

    // Combinational table, one vector per 10 ns.
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      fromPC = vecs[i].pc;
      #10;
      check($sformatf("vec%0d_next", i), NextoPC, vecs[i].expNext);
      check($sformatf("vec%0d_wrap", i), {31'b0, wrap}, {31'b0, vecs[i].expWrap});
      check($sformatf("vec%0d_mis", i), {31'b0, misaligned}, {31'b0, vecs[i].expMis});
    end

    // Wrap is registered with en high.
    @(negedge clk);
    fromPC = 32'hFFFF_FFFC;
    en     = 1'b1;
    tick();
    check("wrapload_q", NextoPC_q, 32'h0000_0000);
    check("wrapload_wrap_q", {31'b0, wrap_q}, 32'h1);

    // en low holds the wrap flag too.
    en     = 1'b0;
    fromPC = 32'h0000_0020;
    tick();
    check("wraphold_q", NextoPC_q, 32'h0000_0000);
    check("wraphold_wrap_q", {31'b0, wrap_q}, 32'h1);

    // Load 0x14, then reset and en together: reset wins, comb path unaffected.
    en     = 1'b1;
    fromPC = 32'h0000_0010;
    tick();
    check("pre_reset_q", NextoPC_q, 32'h0000_0014);
    reset = 1'b1;
    #2;
    check("reset_no_comb_effect", NextoPC, 32'h0000_0014);
    check("reset_no_q_before_edge", NextoPC_q, 32'h0000_0014);
    tick();
    check("reset_prio_q", NextoPC_q, 32'h0000_0000);
    check("reset_prio_wrap_q", {31'b0, wrap_q}, 32'h0);
    check("reset_prio_next", NextoPC, 32'h0000_0014);

    // Load 0x08, then hold for 3 edges while fromPC moves.
    reset  = 1'b0;
    en     = 1'b1;
    fromPC = 32'h0000_0004;
    tick();
    check("load8_q", NextoPC_q, 32'h0000_0008);
    en     = 1'b0;
    fromPC = 32'h0000_0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold%0d_q", k), NextoPC_q, 32'h0000_0008);
    end
    check("hold_next", NextoPC, 32'h0000_0104);

    // Loading resumes once en returns.
    en = 1'b1;
    tick();
    check("resume_q", NextoPC_q, 32'h0000_0104);
    check("resume_wrap_q", {31'b0, wrap_q}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
